// File: rtl/fc_pkg.sv
// Shared types and default sizes for the fully-connected stage sequencer.
package fc_pkg;

  localparam int FC_N_IN  = 9;
  localparam int FC_N_OUT = 4;
  localparam int FC_DW    = 8;
  localparam int FC_WW    = 8;
  localparam int FC_ACC_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } fc_state_e;

endpackage

// File: rtl/fc_mac.sv
// Single signed multiply-accumulate: adds act*w, or the sign-extended bias
// when bias_sel_i is high. Two's complement wrap, no saturation.
module fc_mac #(
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bias_sel_i,
  input  logic [DW-1:0]    act_i,
  input  logic [WW-1:0]    w_i,
  output logic [ACC_W-1:0] acc_o
);

  localparam int PW = DW + WW;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] addend;
  logic [ACC_W-1:0]        acc_q, acc_d;

  assign prod = PW'($signed(act_i)) * PW'($signed(w_i));

  always_comb begin
    addend = bias_sel_i ? ACC_W'($signed(w_i)) : ACC_W'(prod);
    acc_d  = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + addend;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fc_sequencer.sv
// Fully-connected layer sequencer: walks N_OUT neurons, streaming N_IN weights
// plus a bias from a 1-cycle-latency memory into one shared MAC.
module fc_sequencer
  import fc_pkg::*;
#(
  parameter int N_IN  = FC_N_IN,
  parameter int N_OUT = FC_N_OUT,
  parameter int DW    = FC_DW,
  parameter int WW    = FC_WW,
  parameter int ACC_W = FC_ACC_W,
  parameter int AW    = $clog2(N_OUT * (N_IN + 1)),
  localparam int OW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_IN*DW-1:0] in_vec,
  output logic               busy,
  output logic               w_rd_en,
  output logic [AW-1:0]      w_addr,
  input  logic [WW-1:0]      w_data,
  // Result handshake: a result transfers on any rising edge where
  // out_valid and out_ready are both high; out_data/out_idx hold until then.
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic [OW-1:0]      out_idx,
  output logic               done,
  output logic [2:0]         dbg_state
);

  localparam int CW = $clog2(N_IN + 1);
  localparam logic [CW-1:0] LAST_RD = CW'(N_IN);
  localparam logic [OW-1:0] LAST_O  = OW'(N_OUT - 1);
  localparam logic [AW-1:0] STRIDE  = AW'(N_IN + 1);

  fc_state_e          state_q, state_d;
  logic [CW-1:0]      rd_idx_q, rd_idx_d;
  logic [CW-1:0]      ret_idx_q;
  logic               ret_vld_q;
  logic [OW-1:0]      o_q, o_d;
  logic [N_IN*DW-1:0] in_q, in_d;
  logic               acc_clr;
  logic [DW-1:0]      act_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rd_idx_q  <= '0;
      ret_idx_q <= '0;
      ret_vld_q <= 1'b0;
      o_q       <= '0;
      in_q      <= '0;
    end else begin
      state_q   <= state_d;
      rd_idx_q  <= rd_idx_d;
      o_q       <= o_d;
      in_q      <= in_d;
      // Return pipeline mirrors the memory's one-cycle read latency.
      ret_vld_q <= (state_q == ST_READ);
      ret_idx_q <= rd_idx_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    o_d       = o_q;
    in_d      = in_q;
    acc_clr   = 1'b0;
    busy      = 1'b1;
    w_rd_en   = 1'b0;
    w_addr    = '0;
    out_valid = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          in_d     = in_vec;
          acc_clr  = 1'b1;
          o_d      = '0;
          rd_idx_d = '0;
          state_d  = ST_READ;
        end
      end
      ST_READ: begin
        w_rd_en = 1'b1;
        w_addr  = AW'(o_q) * STRIDE + AW'(rd_idx_q);
        if (rd_idx_q == LAST_RD) begin
          rd_idx_d = '0;
          state_d  = ST_DRAIN;
        end else begin
          rd_idx_d = rd_idx_q + CW'(1);
        end
      end
      ST_DRAIN: state_d = ST_EMIT;
      ST_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (o_q == LAST_O) begin
            state_d = ST_DONE;
          end else begin
            o_d     = o_q + OW'(1);
            acc_clr = 1'b1;
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Activation for the returning weight; the bias slot selects nothing.
  always_comb begin
    act_sel = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (ret_idx_q == CW'(k)) act_sel = in_q[k*DW +: DW];
    end
  end

  fc_mac #(
    .DW   (DW),
    .WW   (WW),
    .ACC_W(ACC_W)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (acc_clr),
    .en_i      (ret_vld_q),
    .bias_sel_i(ret_idx_q == LAST_RD),
    .act_i     (act_sel),
    .w_i       (w_data),
    .acc_o     (out_data)
  );

  assign out_idx   = o_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fc_sequencer.sv
// Bench for fc_sequencer: table rows, hand-written corner sequences and random
// layers, checked against an arithmetic reference model and a cycle timeline.
module tb_fc_sequencer;

  localparam int N_IN  = 9;
  localparam int N_OUT = 4;
  localparam int DW    = 8;
  localparam int AW    = 6;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [N_IN*DW-1:0] in_vec;
  logic out_ready;

  logic busy, w_rd_en, out_valid, done;
  logic [AW-1:0] w_addr;
  logic [7:0] w_data;
  logic [31:0] out_data;
  logic [1:0] out_idx;
  logic [2:0] dbg_state;

  logic busy16, w_rd_en16, out_valid16, done16;
  logic [AW-1:0] w_addr16;
  logic [7:0] w_data16;
  logic [15:0] out_data16;
  logic [1:0] out_idx16;
  logic [2:0] dbg_state16;

  logic signed [7:0] mem [64];
  int act_v [N_IN];
  logic [31:0] exp_q[$];
  logic [15:0] exp16_q[$];
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int act_base; int act_step; int w_val; int b_base; int b_step; int exp0; int exp_step;
  } vec_t;
  vec_t tbl [5];

  always #5 clk = ~clk;

  fc_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .in_vec(in_vec), .busy(busy),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .done(done),
    .dbg_state(dbg_state)
  );

  fc_sequencer #(.ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .in_vec(in_vec), .busy(busy16),
    .w_rd_en(w_rd_en16), .w_addr(w_addr16), .w_data(w_data16), .out_valid(out_valid16),
    .out_ready(out_ready), .out_data(out_data16), .out_idx(out_idx16), .done(done16),
    .dbg_state(dbg_state16)
  );

  // Synchronous weight memory, one-cycle read latency.
  always @(posedge clk) begin
    if (w_rd_en) w_data <= mem[w_addr];
    if (w_rd_en16) w_data16 <= mem[w_addr16];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint neuron_ref(input int o);
    longint s = 0;
    for (int k = 0; k < N_IN; k++)
      s += longint'(act_v[k]) * longint'(mem[o*(N_IN+1)+k]);
    s += longint'(mem[o*(N_IN+1)+N_IN]);
    return s;
  endfunction

  task automatic push_model(input bit use_tbl, input int exp0, input int step);
    logic [63:0] sv;
    int e;
    for (int o = 0; o < N_OUT; o++) begin
      sv = neuron_ref(o);
      e  = exp0 + step * o;
      exp16_q.push_back(sv[15:0]);
      if (use_tbl) exp_q.push_back(e);
      else exp_q.push_back(sv[31:0]);
    end
  endtask

  task automatic load_row(input vec_t r);
    for (int k = 0; k < N_IN; k++) act_v[k] = r.act_base + r.act_step * k;
    for (int o = 0; o < N_OUT; o++) begin
      for (int k = 0; k < N_IN; k++) mem[o*(N_IN+1)+k] = 8'(r.w_val);
      mem[o*(N_IN+1)+N_IN] = 8'(r.b_base + r.b_step * o);
    end
    push_model(1'b1, r.exp0, r.exp_step);
  endtask

  task automatic load_random();
    for (int k = 0; k < N_IN; k++) act_v[k] = int'($urandom_range(0, 255)) - 128;
    for (int a = 0; a < N_OUT*(N_IN+1); a++) mem[a] = 8'($urandom_range(0, 255));
    push_model(1'b0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_idx"}, out_idx, 0);
    chk({tag, "_w_rd_en"}, w_rd_en, 0);
    chk({tag, "_w_addr"}, w_addr, 0);
    chk({tag, "_state"}, dbg_state, 0);
    chk({tag, "_dut16"}, {busy16, done16, out_valid16, w_rd_en16, out_data16, out_idx16,
                          w_addr16, dbg_state16}, 0);
  endtask

  // mode 0: ready always high; 1: random ready; 2: 5-cycle stall on neuron 1.
  task automatic run_layer(input int mode, input bit poke, input bit do_rst, output int done_rel);
    int n, s, stall_cnt;
    bit ready, fin, exp_rd, exp_ov, exp_done, exp_busy;
    logic [AW-1:0] exp_addr;
    logic [N_IN*DW-1:0] v;
    n = 0; s = 1; stall_cnt = 0; fin = 1'b0; done_rel = -1;
    for (int k = 0; k < N_IN; k++) v[k*DW +: DW] = DW'(act_v[k]);
    @(negedge clk);
    in_vec = v; start = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    for (int rel = 1; rel <= 600 && !fin; rel++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && rel == 1) in_vec = (N_IN*DW)'({$urandom(), $urandom(), $urandom()});
      if (poke && rel == 20) start = 1'b1;
      exp_rd   = (n < N_OUT) && rel >= s && rel <= s + N_IN;
      exp_addr = exp_rd ? AW'(n*(N_IN+1) + rel - s) : '0;
      exp_ov   = (n < N_OUT) && rel >= s + N_IN + 2;
      exp_done = (n == N_OUT) && rel == s;
      exp_busy = !((n == N_OUT) && rel > s);
      if (do_rst && n == 2 && rel == s + 6) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        exp16_q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        return;
      end
      chk("busy", busy, exp_busy);
      chk("w_rd_en", w_rd_en, exp_rd);
      chk("w_addr", w_addr, exp_addr);
      chk("out_valid", out_valid, exp_ov);
      chk("done", done, exp_done);
      chk("ctl16", {busy16, w_rd_en16, out_valid16, done16}, {exp_busy, exp_rd, exp_ov, exp_done});
      if (done && done_rel < 0) done_rel = rel;
      if (exp_ov) begin
        case (mode)
          0: ready = 1'b1;
          1: ready = 1'($urandom_range(0, 1));
          default: ready = !(n == 1 && stall_cnt < 5);
        endcase
        if (mode == 2 && !ready) stall_cnt++;
        if (exp_q.size() == 0 || exp16_q.size() == 0) begin
          chk("exp_queue_empty", 1, 0);
        end else if (ready) begin
          chk("out_data", out_data, exp_q.pop_front());
          chk("out_idx", out_idx, n);
          chk("out_data16", out_data16, exp16_q.pop_front());
          chk("out_idx16", out_idx16, n);
          n++;
          s = rel + 1;
        end else begin
          chk("hold_data", out_data, exp_q[0]);
          chk("hold_idx", out_idx, n);
        end
      end else begin
        ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      out_ready = ready;
      if (exp_done && poke) start = 1'b1;
      if (n == N_OUT && rel == s + 1) fin = 1'b1;
    end
    n_checks++;
    if (!fin) begin
      n_fail++;
      $display("FAIL layer_timeout actual=not_finished required=finished");
    end
    out_ready = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int drel;
    tbl[0] = '{1, 0, 1, 0, 0, 9, 0};
    tbl[1] = '{0, 1, 2, 0, 1, 72, 1};
    tbl[2] = '{-128, 0, -128, 127, 0, 147583, 0};
    tbl[3] = '{127, 0, -128, -128, 0, -146432, 0};
    tbl[4] = '{-3, 1, 5, -10, 3, 35, 3};

    rst = 1'b1; start = 1'b0; in_vec = '0; out_ready = 1'b0;
    for (int a = 0; a < 64; a++) mem[a] = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      load_row(tbl[i]);
      run_layer(0, 1'b0, 1'b0, drel);
      if (i == 0) chk("done_cycle", drel, 49);
    end

    load_row(tbl[1]);
    run_layer(2, 1'b0, 1'b0, drel);
    chk("done_cycle_stall", drel, 54);

    load_row(tbl[4]);
    run_layer(0, 1'b1, 1'b0, drel);

    load_row(tbl[1]);
    run_layer(0, 1'b0, 1'b1, drel);
    load_row(tbl[1]);
    run_layer(0, 1'b0, 1'b0, drel);
    chk("done_cycle_after_rst", drel, 49);

    for (int i = 0; i < 6; i++) begin
      load_random();
      run_layer(1, 1'b0, 1'b0, drel);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
